// File: rtl/multi_ch_accum.sv
// multi_ch_accum: multi-channel triggered accumulator.
// An enable pulse latches an addend, a target channel and an arithmetic mode, waits
// WAIT_CYCLES cycles, then adds the addend into that channel (wrapping or saturating).
// One channel's bit window drives the LEDs; a second selector gives full-width readback.
module multi_ch_accum #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NCH         = 4,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned LED_LSB     = 16,
    parameter int unsigned LED_W       = 8,
    localparam int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             enable,
    input  logic [CW-1:0]    ch_sel,
    input  logic [WIDTH-1:0] value,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic [CW-1:0]    clr_ch,
    input  logic [CW-1:0]    led_ch,
    input  logic [CW-1:0]    rd_ch,
    output logic [LED_W-1:0] led,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [NCH-1:0]   ovf
);

    // The wait counter only ever holds values up to WAIT_CYCLES-1.
    localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAcc  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WIDTH-1:0] r_value;
    logic [CW-1:0]    r_ch;
    logic             r_sat;
    logic             r_done;

    logic [WIDTH-1:0] r_count [NCH];
    logic [NCH-1:0]   r_ovf;

    logic             w_add;
    logic [WIDTH-1:0] w_sel_count;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_result;

    // Control FSM: latch the request in idle, count down the wait, pulse done on the add.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
            r_value    <= '0;
            r_ch       <= '0;
            r_sat      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (enable) begin
                        r_value <= value;
                        r_ch    <= ch_sel;
                        r_sat   <= sat_mode;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= StAcc;
                        end else begin
                            r_state    <= StWait;
                            r_wait_cnt <= WCW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                StWait: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= StAcc;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                StAcc: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_add = (r_state == StAcc);

    // Select the target channel's current count; an out-of-range index selects nothing.
    always_comb begin
        w_sel_count = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_ch == CW'(i)) begin
                w_sel_count = r_count[i];
            end
        end
    end

    // Unsigned add with carry out; saturate clamps to all-ones on carry.
    always_comb begin
        w_sum    = {1'b0, w_sel_count} + {1'b0, r_value};
        w_carry  = w_sum[WIDTH];
        w_result = (r_sat && w_carry) ? '1 : w_sum[WIDTH-1:0];
    end

    // Per-channel counts and sticky overflow; a clear on the same channel beats the add.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NCH; i++) begin
                r_count[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr && (clr_ch == CW'(i))) begin
                    r_count[i] <= '0;
                    r_ovf[i]   <= 1'b0;
                end else if (w_add && (r_ch == CW'(i))) begin
                    r_count[i] <= w_result;
                    if (w_carry) begin
                        r_ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Readback muxes; out-of-range selectors read as zero.
    always_comb begin
        led     = '0;
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (led_ch == CW'(i)) begin
                led = r_count[i][LED_LSB +: LED_W];
            end
            if (rd_ch == CW'(i)) begin
                rd_data = r_count[i];
            end
        end
    end

    assign busy = (r_state != StIdle);
    assign done = r_done;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_multi_ch_accum.sv
// Self-checking bench for multi_ch_accum: a default instance (NCH=4, WAIT_CYCLES=1) and a
// second instance (NCH=5, WAIT_CYCLES=0) whose 3-bit selectors reach out-of-range channels.
module tb_multi_ch_accum;

    localparam int NCH_A  = 4;
    localparam int NCH_B  = 5;
    localparam int WAIT_A = 1;
    localparam int WAIT_B = 0;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;

    logic        enable = 1'b0;
    logic [1:0]  ch_sel = '0;
    logic [31:0] value = '0;
    logic        sat_mode = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  clr_ch = '0;
    logic [1:0]  led_ch = '0;
    logic [1:0]  rd_ch = '0;
    logic [7:0]  led;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [3:0]  ovf;

    logic        b_enable = 1'b0;
    logic [2:0]  b_ch_sel = '0;
    logic [31:0] b_value = '0;
    logic        b_sat_mode = 1'b0;
    logic        b_clr = 1'b0;
    logic [2:0]  b_clr_ch = '0;
    logic [2:0]  b_led_ch = '0;
    logic [2:0]  b_rd_ch = '0;
    logic [7:0]  b_led;
    logic [31:0] b_rd_data;
    logic        b_busy;
    logic        b_done;
    logic [4:0]  b_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: [instance][channel], instance 0 = A, 1 = B.
    logic [31:0] m_cnt [2][5];
    bit          m_ovf [2][5];

    always #10 CLK = ~CLK;

    multi_ch_accum u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .ch_sel(ch_sel), .value(value),
        .sat_mode(sat_mode), .clr(clr), .clr_ch(clr_ch), .led_ch(led_ch), .rd_ch(rd_ch),
        .led(led), .rd_data(rd_data), .busy(busy), .done(done), .ovf(ovf)
    );

    multi_ch_accum #(.NCH(NCH_B), .WAIT_CYCLES(WAIT_B)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .enable(b_enable), .ch_sel(b_ch_sel), .value(b_value),
        .sat_mode(b_sat_mode), .clr(b_clr), .clr_ch(b_clr_ch), .led_ch(b_led_ch),
        .rd_ch(b_rd_ch), .led(b_led), .rd_data(b_rd_data), .busy(b_busy), .done(b_done),
        .ovf(b_ovf)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 5; c++) begin
                m_cnt[k][c] = '0;
                m_ovf[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_add(input int inst, input int ch, input logic [31:0] v, input bit sat);
        longint unsigned s;
        int nch;
        nch = (inst != 0) ? NCH_B : NCH_A;
        if (ch >= nch) return;
        s = 64'(m_cnt[inst][ch]) + 64'(v);
        if (s > 64'hFFFF_FFFF) begin
            m_ovf[inst][ch] = 1'b1;
            m_cnt[inst][ch] = sat ? 32'hFFFF_FFFF : 32'(s - 64'h1_0000_0000);
        end else begin
            m_cnt[inst][ch] = 32'(s);
        end
    endtask

    task automatic model_clr(input int inst, input int ch);
        int nch;
        nch = (inst != 0) ? NCH_B : NCH_A;
        if (ch >= nch) return;
        m_cnt[inst][ch] = '0;
        m_ovf[inst][ch] = 1'b0;
    endtask

    function automatic logic [3:0] exp_ovf_a();
        logic [3:0] e;
        for (int c = 0; c < NCH_A; c++) e[c] = m_ovf[0][c];
        return e;
    endfunction

    function automatic logic [4:0] exp_ovf_b();
        logic [4:0] e;
        for (int c = 0; c < NCH_B; c++) e[c] = m_ovf[1][c];
        return e;
    endfunction

    // Single request on A, idle on entry; lat = edges from acceptance to done, -1 on timeout.
    task automatic do_txn_a(input logic [1:0] ch, input logic [31:0] v, input bit sat,
                            output int lat);
        enable = 1'b1; ch_sel = ch; value = v; sat_mode = sat;
        tick();
        enable = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_txn_b(input logic [2:0] ch, input logic [31:0] v, input bit sat,
                            output int lat);
        b_enable = 1'b1; b_ch_sel = ch; b_value = v; b_sat_mode = sat;
        tick();
        b_enable = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (b_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic clr_a(input logic [1:0] ch);
        clr = 1'b1; clr_ch = ch;
        tick();
        clr = 1'b0;
        model_clr(0, int'(ch));
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovf !== 4'b0 || rd_data !== 32'b0 || led !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_a: got busy=%b done=%b ovf=%h rd=%h led=%h want all zero",
                     busy, done, ovf, rd_data, led);
        end
        n_checks++;
        if (b_busy !== 1'b0 || b_done !== 1'b0 || b_ovf !== 5'b0 || b_rd_data !== 32'b0) begin
            n_fail++;
            $display("FAIL reset_b: got busy=%b done=%b ovf=%h rd=%h want all zero",
                     b_busy, b_done, b_ovf, b_rd_data);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] e;
        led_ch = 2'd0; rd_ch = 2'd0;
        enable = 1'b1; ch_sel = 2'd0; value = 32'h0001_0000; sat_mode = 1'b0;
        tick();
        enable = 1'b0;
        model_add(0, 0, 32'h0001_0000, 1'b0);
        e = m_cnt[0][0];
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cycle1: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_cycle2: got busy=%b done=%b rd=%h want 1 0 0",
                     busy, done, rd_data);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || rd_data !== e || led !== e[23:16]) begin
            n_fail++;
            $display("FAIL basic_update: got busy=%b done=%b rd=%h led=%h want 0 1 %h %h",
                     busy, done, rd_data, led, e, e[23:16]);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_wrap();
        int lat;
        clr_a(2'd1);
        do_txn_a(2'd1, 32'hFFFF_FFF0, 1'b0, lat);
        model_add(0, 1, 32'hFFFF_FFF0, 1'b0);
        do_txn_a(2'd1, 32'h20, 1'b0, lat);
        model_add(0, 1, 32'h20, 1'b0);
        rd_ch = 2'd1;
        #1;
        n_checks++;
        if (lat != WAIT_A + 1 || rd_data !== m_cnt[0][1] || ovf !== exp_ovf_a()) begin
            n_fail++;
            $display("FAIL wrap_add: got lat=%0d rd=%h ovf=%b want lat=%0d rd=%h ovf=%b",
                     lat, rd_data, ovf, WAIT_A + 1, m_cnt[0][1], exp_ovf_a());
        end
        clr_a(2'd1);
        n_checks++;
        if (rd_data !== m_cnt[0][1] || ovf !== exp_ovf_a()) begin
            n_fail++;
            $display("FAIL wrap_clr: got rd=%h ovf=%b want rd=%h ovf=%b",
                     rd_data, ovf, m_cnt[0][1], exp_ovf_a());
        end
    endtask

    task automatic test_saturate();
        int lat;
        clr_a(2'd2);
        rd_ch = 2'd2;
        do_txn_a(2'd2, 32'hFFFF_FFF0, 1'b1, lat);
        model_add(0, 2, 32'hFFFF_FFF0, 1'b1);
        do_txn_a(2'd2, 32'h20, 1'b1, lat);
        model_add(0, 2, 32'h20, 1'b1);
        n_checks++;
        if (rd_data !== m_cnt[0][2] || ovf !== exp_ovf_a()) begin
            n_fail++;
            $display("FAIL sat_add: got rd=%h ovf=%b want rd=%h ovf=%b",
                     rd_data, ovf, m_cnt[0][2], exp_ovf_a());
        end
        do_txn_a(2'd2, 32'h5, 1'b1, lat);
        model_add(0, 2, 32'h5, 1'b1);
        n_checks++;
        if (rd_data !== m_cnt[0][2] || ovf !== exp_ovf_a()) begin
            n_fail++;
            $display("FAIL sat_hold: got rd=%h ovf=%b want rd=%h ovf=%b",
                     rd_data, ovf, m_cnt[0][2], exp_ovf_a());
        end
    endtask

    // enable held for 9 sampled edges; a request is accepted only once the previous one
    // has finished, i.e. WAIT_CYCLES+2 edges after the last acceptance.
    task automatic test_back_to_back();
        int acc_a = 0, acc_b = 0, nxt_a = 0, nxt_b = 0, dn_a = 0, dn_b = 0;
        clr = 1'b1; clr_ch = 2'd3; b_clr = 1'b1; b_clr_ch = 3'd3;
        tick();
        clr = 1'b0; b_clr = 1'b0;
        model_clr(0, 3);
        model_clr(1, 3);
        enable = 1'b1; ch_sel = 2'd3; value = 32'd5; sat_mode = 1'b0;
        b_enable = 1'b1; b_ch_sel = 3'd3; b_value = 32'd5; b_sat_mode = 1'b0;
        for (int e = 0; e < 9; e++) begin
            if (e >= nxt_a) begin
                acc_a++; nxt_a = e + WAIT_A + 2; model_add(0, 3, 32'd5, 1'b0);
            end
            if (e >= nxt_b) begin
                acc_b++; nxt_b = e + WAIT_B + 2; model_add(1, 3, 32'd5, 1'b0);
            end
            tick();
            if (done === 1'b1) dn_a++;
            if (b_done === 1'b1) dn_b++;
        end
        enable = 1'b0; b_enable = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            if (done === 1'b1) dn_a++;
            if (b_done === 1'b1) dn_b++;
        end
        rd_ch = 2'd3; b_rd_ch = 3'd3;
        #1;
        n_checks++;
        if (dn_a != acc_a || rd_data !== m_cnt[0][3]) begin
            n_fail++;
            $display("FAIL b2b_wait1: got dones=%0d rd=%h want dones=%0d rd=%h",
                     dn_a, rd_data, acc_a, m_cnt[0][3]);
        end
        n_checks++;
        if (dn_b != acc_b || b_rd_data !== m_cnt[1][3]) begin
            n_fail++;
            $display("FAIL b2b_wait0: got dones=%0d rd=%h want dones=%0d rd=%h",
                     dn_b, b_rd_data, acc_b, m_cnt[1][3]);
        end
    endtask

    task automatic test_collision();
        int lat;
        clr_a(2'd0);
        clr_a(2'd1);
        do_txn_a(2'd1, 32'h77, 1'b0, lat);
        model_add(0, 1, 32'h77, 1'b0);
        do_txn_a(2'd0, 32'h11, 1'b0, lat);
        model_add(0, 0, 32'h11, 1'b0);
        // Same channel: clear lands on the add edge.
        enable = 1'b1; ch_sel = 2'd0; value = 32'h33; sat_mode = 1'b0;
        tick();
        enable = 1'b0;
        repeat (WAIT_A) tick();
        clr = 1'b1; clr_ch = 2'd0;
        tick();
        clr = 1'b0;
        model_add(0, 0, 32'h33, 1'b0);
        model_clr(0, 0);
        rd_ch = 2'd0;
        #1;
        n_checks++;
        if (done !== 1'b1 || rd_data !== m_cnt[0][0]) begin
            n_fail++;
            $display("FAIL coll_same: got done=%b rd=%h want done=1 rd=%h",
                     done, rd_data, m_cnt[0][0]);
        end
        tick();
        // Different channels: both take effect.
        enable = 1'b1; ch_sel = 2'd0; value = 32'h44;
        tick();
        enable = 1'b0;
        repeat (WAIT_A) tick();
        clr = 1'b1; clr_ch = 2'd1;
        tick();
        clr = 1'b0;
        model_add(0, 0, 32'h44, 1'b0);
        model_clr(0, 1);
        rd_ch = 2'd0;
        #1;
        n_checks++;
        if (done !== 1'b1 || rd_data !== m_cnt[0][0]) begin
            n_fail++;
            $display("FAIL coll_diff_add: got done=%b rd=%h want done=1 rd=%h",
                     done, rd_data, m_cnt[0][0]);
        end
        rd_ch = 2'd1;
        #1;
        n_checks++;
        if (rd_data !== m_cnt[0][1]) begin
            n_fail++;
            $display("FAIL coll_diff_clr: got rd=%h want %h", rd_data, m_cnt[0][1]);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [4:0] ov_before;
        do_txn_b(3'd1, 32'h00AB_0000, 1'b0, lat);
        model_add(1, 1, 32'h00AB_0000, 1'b0);
        ov_before = b_ovf;
        do_txn_b(3'd6, 32'hFFFF_FFFF, 1'b0, lat);
        model_add(1, 6, 32'hFFFF_FFFF, 1'b0);
        b_clr = 1'b1; b_clr_ch = 3'd7;
        tick();
        b_clr = 1'b0;
        model_clr(1, 7);
        n_checks++;
        if (lat != WAIT_B + 1 || b_ovf !== exp_ovf_b()) begin
            n_fail++;
            $display("FAIL oor_add: got lat=%0d ovf=%b (before %b) want lat=%0d ovf=%b",
                     lat, b_ovf, ov_before, WAIT_B + 1, exp_ovf_b());
        end
        for (int c = 0; c < 8; c++) begin
            b_rd_ch = 3'(c); b_led_ch = 3'(c);
            #1;
            n_checks++;
            if (c < NCH_B) begin
                if (b_rd_data !== m_cnt[1][c] || b_led !== m_cnt[1][c][23:16]) begin
                    n_fail++;
                    $display("FAIL oor_read_ch%0d: got rd=%h led=%h want rd=%h led=%h",
                             c, b_rd_data, b_led, m_cnt[1][c], m_cnt[1][c][23:16]);
                end
            end else if (b_rd_data !== 32'h0 || b_led !== 8'h0) begin
                n_fail++;
                $display("FAIL oor_read_ch%0d: got rd=%h led=%h want rd=0 led=0",
                         c, b_rd_data, b_led);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [1:0] ch;
        logic [31:0] v;
        bit sat;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) clr_a(2'($urandom_range(0, 3)));
            ch  = 2'($urandom_range(0, 3));
            v   = ($urandom_range(0, 2) == 0) ? (32'hF000_0000 | $urandom) : $urandom;
            sat = 1'($urandom_range(0, 1));
            do_txn_a(ch, v, sat, lat);
            model_add(0, int'(ch), v, sat);
            rd_ch = ch; led_ch = ch;
            #1;
            n_checks++;
            if (lat != WAIT_A + 1 || rd_data !== m_cnt[0][ch] || led !== m_cnt[0][ch][23:16]
                || ovf !== exp_ovf_a()) begin
                n_fail++;
                $display("FAIL rand_%0d: got lat=%0d rd=%h led=%h ovf=%b want %0d %h %h %b",
                         n, lat, rd_data, led, ovf, WAIT_A + 1, m_cnt[0][ch],
                         m_cnt[0][ch][23:16], exp_ovf_a());
            end
        end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        enable = 1'b1; ch_sel = 2'd2; value = 32'h1234; sat_mode = 1'b0;
        b_enable = 1'b1; b_ch_sel = 3'd1; b_value = 32'd9; b_sat_mode = 1'b0;
        tick();
        enable = 1'b0; b_enable = 1'b0;
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (busy !== 1'b0 || b_busy !== 1'b0 || ovf !== 4'b0 || b_ovf !== 5'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: got busy=%b b_busy=%b ovf=%b b_ovf=%b want all 0",
                     busy, b_busy, ovf, b_ovf);
        end
        for (int c = 0; c < NCH_A; c++) begin
            rd_ch = 2'(c);
            #1;
            n_checks++;
            if (rd_data !== m_cnt[0][c]) begin
                n_fail++;
                $display("FAIL rstmid_cnt_a%0d: got %h want %h", c, rd_data, m_cnt[0][c]);
            end
        end
        tick();
        RST_N = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            if (done === 1'b1 || b_done === 1'b1) dn++;
        end
        rd_ch = 2'd2; b_rd_ch = 3'd1;
        #1;
        n_checks++;
        if (dn != 0 || busy !== 1'b0 || rd_data !== m_cnt[0][2] || b_rd_data !== m_cnt[1][1]) begin
            n_fail++;
            $display("FAIL rstmid_after: got dones=%0d busy=%b rd=%h b_rd=%h want 0 0 %h %h",
                     dn, busy, rd_data, b_rd_data, m_cnt[0][2], m_cnt[1][1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_saturate();
        test_back_to_back();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_ch_accum.md
Name: multi_ch_accum

Overview:
- Parametrised successor to the single-channel triggered accumulator.
- An enable pulse latches a value and a channel index, waits a programmable number of cycles, then adds the value into that channel's accumulator (wrap or saturate).
- A selectable bit window of a selectable channel drives the board LEDs; a second selector gives full-width readback.
- Sits between the control/stimulus logic and the LED/debug outputs in the top-level design.

Parameters:
- WIDTH, 32: accumulator and value width in bits (≥ 8).
- NCH, 4: number of accumulator channels (≥ 1); index width CW = max(1, clog2(NCH)).
- WAIT_CYCLES, 1: number of WAIT-state cycles between acceptance and add (≥ 0).
- LED_LSB, 16: lowest accumulator bit shown on led; LED_LSB+LED_W ≤ WIDTH.
- LED_W, 8: led width.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- enable  in  1  start request; sampled only in IDLE.
- ch_sel  in  CW  target channel, latched with enable.
- value  in  WIDTH  addend, latched with enable.
- sat_mode  in  1  latched with enable; 1 = saturate, 0 = wrap.
- clr  in  1  synchronous clear strobe.
- clr_ch  in  CW  channel cleared by clr.
- led_ch  in  CW  channel driving led.
- rd_ch  in  CW  channel driving rd_data.
- led  out  LED_W  count[led_ch][LED_LSB+LED_W-1:LED_LSB], combinational.
- rd_data  out  WIDTH  count[rd_ch], combinational.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse, registered with the accumulator update.
- ovf  out  NCH  per-channel sticky overflow flags.

Behaviour:
- Reset (RST_N low, asynchronous):
  - all count[] = 0, ovf = 0, done = 0, FSM = IDLE, latched registers = 0.
  - Reset asserted mid-operation aborts the operation; no add occurs.
- FSM states: IDLE, WAIT, ACC.
  - IDLE: at a clock edge with enable = 1, latch value, ch_sel and sat_mode. Go to WAIT with wait counter = WAIT_CYCLES-1, or directly to ACC if WAIT_CYCLES = 0.
  - WAIT: decrement the counter each cycle; go to ACC when it reaches 0. enable is ignored (no queueing).
  - ACC: on the next edge, perform the add, pulse done, return to IDLE.
- Latency:
  - Enable sampled at edge N → count updated and done high after edge N+WAIT_CYCLES+1.
  - Next enable is accepted at edge N+WAIT_CYCLES+2 at the earliest; an enable held high re-triggers back to back.
- Arithmetic: unsigned, sum = count + value with a WIDTH+1-bit carry.
  - Wrap mode: count = sum mod 2^WIDTH; ovf[ch] set if carry.
  - Saturate mode: count = all-ones if carry, else sum; ovf[ch] set if carry.
  - ovf bits are sticky until clr or reset.
- Out-of-range channels (index ≥ NCH, for ch_sel/clr_ch/led_ch/rd_ch):
  - ch_sel out of range: add is dropped, done still pulses.
  - clr_ch out of range: clr is ignored.
  - led_ch/rd_ch out of range: led and rd_data read 0.
- clr: at the edge with clr = 1, count[clr_ch] = 0 and ovf[clr_ch] = 0.
  - Clear-vs-add collision at the same edge on the same channel: clear wins, add discarded, done still pulses.
  - Collision on different channels: both take effect.
- clr is independent of FSM state and does not affect busy.

Test Plan:
- Defaults; enable one cycle with value=0x0001_0000, ch_sel=0 → after 3 edges count[0]=0x0001_0000, led(led_ch=0)=0x01, done one-cycle pulse, busy high for 2 cycles.
- Wrap: count[1]=0xFFFF_FFF0, add 0x20 with sat_mode=0 → count[1]=0x10, ovf[1]=1; clr with clr_ch=1 → count[1]=0, ovf[1]=0.
- Saturate: count[2]=0xFFFF_FFF0, add 0x20 with sat_mode=1 → count[2]=0xFFFF_FFFF, ovf[2]=1; a further add keeps 0xFFFF_FFFF.
- enable held high 10 cycles, value=5, ch=3, WAIT_CYCLES=1 → exactly 3 adds complete (count[3]=15), enable ignored while busy; rerun with WAIT_CYCLES=0 → 5 adds.
- clr on ch0 at the same edge as the ACC add to ch0 → count[0]=0, done pulses; same collision with clr_ch=1 → both take effect.
- RST_N asserted asynchronously mid-WAIT → immediate return to IDLE, all counts 0; no done pulse and no add after release.
